imm_gen_stage: RTL and testbench

- Parametrised, pipelined immediate generator for the ID stage. Supports XLEN 32 or 64.
- Decodes the RISC-V format (I/S/B/U/J/CSR-Z) from the opcode and produces a sign-extended XLEN immediate.
- Precomputes the PC-relative target for B and J formats.
- Sits between the fetch/decode buffer and the register-read stage, using valid/ready handshakes. A 2-entry skid buffer gives full throughput under backpressure.

---
 rtl/imm_gen_stage.sv | 177 +++++++++++++++++
 tb/tb_imm_gen_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator with PC-relative target precompute.
// Two-entry (output + skid) valid/ready pipeline stage.
module imm_gen_stage #(
   parameter int XLEN     = 32,
   parameter int CSR_ZIMM = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [XLEN-1:0] out_target
);

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
      logic [XLEN-1:0] target;
   } ent_t;

   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_FENCE = 7'b0001111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OP_32    = 7'b0111011;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam logic [2:0] F_R   = 3'd0;
   localparam logic [2:0] F_I   = 3'd1;
   localparam logic [2:0] F_S   = 3'd2;
   localparam logic [2:0] F_B   = 3'd3;
   localparam logic [2:0] F_U   = 3'd4;
   localparam logic [2:0] F_J   = 3'd5;
   localparam logic [2:0] F_Z   = 3'd6;
   localparam logic [2:0] F_ILL = 3'd7;

   localparam logic RV64 = (XLEN == 64);
   localparam logic ZIMM = (CSR_ZIMM != 0);

   ent_t            dec;
   ent_t            out_q;
   ent_t            skid_q;
   logic            out_v;
   logic            skid_v;
   logic            acc;
   logic            zsel;
   logic [6:0]      op;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_z;

   assign op    = in_instr[6:0];
   assign zsel  = ZIMM & in_instr[14];
   assign imm_i = XLEN'($signed(in_instr[31:20]));
   assign imm_s = XLEN'($signed({in_instr[31:25],
                                 in_instr[11:7]}));
   assign imm_b = XLEN'($signed({in_instr[31], in_instr[7],
                                 in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({in_instr[31],
                                 in_instr[19:12],
                                 in_instr[20],
                                 in_instr[30:21], 1'b0}));
   assign imm_z = XLEN'(in_instr[19:15]);

   always_comb begin
      dec       = '0;
      dec.instr = in_instr;
      dec.pc    = in_pc;
      unique case (1'b1)
         (op == OP_BR): begin
            dec.fmt = F_B;
            dec.imm = imm_b;
         end
         (op == OP_JALR), (op == OP_IMM),
         (op == OP_LD), (op == OP_FENCE): begin
            dec.fmt = F_I;
            dec.imm = imm_i;
         end
         (op == OP_JAL): begin
            dec.fmt = F_J;
            dec.imm = imm_j;
         end
         (op == OP_LUI), (op == OP_AUIPC): begin
            dec.fmt = F_U;
            dec.imm = imm_u;
         end
         (op == OP_ST): begin
            dec.fmt = F_S;
            dec.imm = imm_s;
         end
         (op == OP_OP): dec.fmt = F_R;
         (op == OP_IMM32) && RV64: begin
            dec.fmt = F_I;
            dec.imm = imm_i;
         end
         (op == OP_32) && RV64: dec.fmt = F_R;
         (op == OP_SYS) && zsel: begin
            dec.fmt = F_Z;
            dec.imm = imm_z;
         end
         (op == OP_SYS) && !zsel: begin
            dec.fmt = F_I;
            dec.imm = imm_i;
         end
         default: begin
            dec.fmt     = F_ILL;
            dec.illegal = 1'b1;
         end
      endcase
      if (dec.fmt == F_B || dec.fmt == F_J)
         dec.target = in_pc + dec.imm;
   end

   // skid_v alone gates acceptance, so in_ready is a pure flop output
   assign in_ready = ~skid_v;
   assign acc      = in_valid & ~skid_v;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (flush) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (!out_v || out_ready) begin
         if (skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= acc;
            if (acc)
               skid_q <= dec;
         end else begin
            out_v <= acc;
            if (acc)
               out_q <= dec;
         end
      end else if (acc) begin
         skid_q <= dec;
         skid_v <= 1'b1;
      end
   end

   assign out_valid   = out_v;
   assign out_instr   = out_q.instr;
   assign out_pc      = out_q.pc;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_target  = out_q.target;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: RV32/ZIMM=1 and RV64/ZIMM=0 instances
// share stimulus; a queue model tracks held entries.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;

   logic        r32, v32, il32;
   logic [31:0] i32, pc32, imm32, tg32;
   logic [2:0]  f32;
   logic        r64, v64, il64;
   logic [31:0] i64;
   logic [63:0] pc64, imm64, tg64;
   logic [2:0]  f64;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } ent_t;

   typedef struct {
      logic [2:0]  fmt;
      logic        ill;
      logic [63:0] imm;
      logic [63:0] tgt;
   } exp_t;

   ent_t q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   logic [6:0] ops [13] = '{
      7'b1100011, 7'b1100111, 7'b0010011, 7'b0000011,
      7'b0001111, 7'b1101111, 7'b0110111, 7'b0010111,
      7'b0100011, 7'b0110011, 7'b0011011, 7'b0111011,
      7'b1110011
   };

   always #5 clk = ~clk;

   imm_gen_stage #(.XLEN(32), .CSR_ZIMM(1)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r32),
      .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(v32), .out_ready(out_ready),
      .out_instr(i32), .out_pc(pc32), .out_imm(imm32),
      .out_fmt(f32), .out_illegal(il32), .out_target(tg32)
   );

   imm_gen_stage #(.XLEN(64), .CSR_ZIMM(0)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(r64),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(v64), .out_ready(out_ready),
      .out_instr(i64), .out_pc(pc64), .out_imm(imm64),
      .out_fmt(f64), .out_illegal(il64), .out_target(tg64)
   );

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h",
                tag, obs, exp);
      end
   endtask

   function automatic longint sx(input longint v, input int n);
      if (v >= (longint'(1) << (n - 1)))
         return v - (longint'(1) << n);
      return v;
   endfunction

   // Expected decode straight from the ISA field layouts
   function automatic exp_t model(input logic [31:0] x,
                                  input logic [63:0] pc,
                                  input int xlen,
                                  input bit zimm);
      exp_t e;
      longint imm, ii;
      logic [63:0] m;
      m   = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
      ii  = sx(longint'(x[31:20]), 12);
      imm = 0;
      e.fmt = 3'd7;
      case (x[6:0])
         7'b1100011: begin
            e.fmt = 3'd3;
            imm = sx(longint'(x[31]) * 4096 +
                     longint'(x[7]) * 2048 +
                     longint'(x[30:25]) * 32 +
                     longint'(x[11:8]) * 2, 13);
         end
         7'b1100111, 7'b0010011,
         7'b0000011, 7'b0001111: begin
            e.fmt = 3'd1;
            imm = ii;
         end
         7'b1101111: begin
            e.fmt = 3'd5;
            imm = sx(longint'(x[31]) * (1 << 20) +
                     longint'(x[19:12]) * (1 << 12) +
                     longint'(x[20]) * (1 << 11) +
                     longint'(x[30:21]) * 2, 21);
         end
         7'b0110111, 7'b0010111: begin
            e.fmt = 3'd4;
            imm = sx(longint'(x[31:12]) * 4096, 32);
         end
         7'b0100011: begin
            e.fmt = 3'd2;
            imm = sx(longint'(x[31:25]) * 32 +
                     longint'(x[11:7]), 12);
         end
         7'b0110011: e.fmt = 3'd0;
         7'b0011011: if (xlen == 64) begin
            e.fmt = 3'd1;
            imm = ii;
         end
         7'b0111011: if (xlen == 64) e.fmt = 3'd0;
         7'b1110011: if (zimm && x[14]) begin
            e.fmt = 3'd6;
            imm = longint'(x[19:15]);
         end else begin
            e.fmt = 3'd1;
            imm = ii;
         end
         default: ;
      endcase
      e.ill = (e.fmt == 3'd7);
      e.imm = 64'(imm) & m;
      e.tgt = (e.fmt == 3'd3 || e.fmt == 3'd5) ?
              ((pc + 64'(imm)) & m) : 64'd0;
      return e;
   endfunction

   // Check at negedge, advance the model, stop at posedge+1
   task automatic cycle();
      exp_t a, b;
      bit acc, fire;
      @(negedge clk);
      chk("in_ready32", 64'(r32), 64'(q.size() < 2));
      chk("in_ready64", 64'(r64), 64'(q.size() < 2));
      chk("out_valid32", 64'(v32), 64'(q.size() > 0));
      chk("out_valid64", 64'(v64), 64'(q.size() > 0));
      if (q.size() > 0) begin
         a = model(q[0].instr, q[0].pc, 32, 1'b1);
         b = model(q[0].instr, q[0].pc, 64, 1'b0);
         chk("instr32", 64'(i32), 64'(q[0].instr));
         chk("pc32", 64'(pc32), 64'(q[0].pc[31:0]));
         chk("imm32", 64'(imm32), a.imm);
         chk("fmt32", 64'(f32), 64'(a.fmt));
         chk("ill32", 64'(il32), 64'(a.ill));
         chk("tgt32", 64'(tg32), a.tgt);
         chk("instr64", 64'(i64), 64'(q[0].instr));
         chk("pc64", pc64, q[0].pc);
         chk("imm64", imm64, b.imm);
         chk("fmt64", 64'(f64), 64'(b.fmt));
         chk("ill64", 64'(il64), 64'(b.ill));
         chk("tgt64", tg64, b.tgt);
      end
      if (rst || flush) begin
         q.delete();
      end else begin
         acc  = in_valid && (q.size() < 2);
         fire = (q.size() > 0) && out_ready;
         if (fire)
            void'(q.pop_front());
         if (acc)
            q.push_back('{in_instr, in_pc});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] x,
                       input logic [63:0] pc);
      in_valid = 1'b1;
      in_instr = x;
      in_pc    = pc;
      cycle();
      in_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      cycle();
      cycle();
      chk("rst_valid", 64'(v32), 64'd0);
      chk("rst_ready", 64'(r32), 64'd1);
      chk("rst_instr", 64'(i32), 64'd0);
      chk("rst_imm", 64'(imm32), 64'd0);
      chk("rst_fmt", 64'(f32), 64'd0);
      chk("rst_ill", 64'(il32), 64'd0);
      chk("rst_tgt", 64'(tg32), 64'd0);
      chk("rst_tgt64", tg64, 64'd0);
      rst       = 1'b0;
      out_ready = 1'b1;

      send(32'hFE000EE3, 64'h100);
      chk("beq_fmt", 64'(f32), 64'd3);
      chk("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
      chk("beq_tgt", 64'(tg32), 64'h0000_00FC);
      send(32'h123450B7, 64'h0);
      chk("lui_fmt", 64'(f32), 64'd4);
      chk("lui_imm", 64'(imm32), 64'h1234_5000);
      send(32'h800000B7, 64'h0);
      chk("lui64_fmt", 64'(f64), 64'd4);
      chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
      send(32'h0080006F, 64'h200);
      chk("jal_fmt", 64'(f32), 64'd5);
      chk("jal_imm", 64'(imm32), 64'd8);
      chk("jal_tgt", 64'(tg32), 64'h208);
      send(32'h3002D073, 64'h40);
      chk("csr_z_fmt", 64'(f32), 64'd6);
      chk("csr_z_imm", 64'(imm32), 64'd5);
      chk("csr_i_fmt", 64'(f64), 64'd1);
      chk("csr_i_imm", imm64, 64'h300);
      send(32'h0000_0000, 64'h0);
      chk("zero_fmt", 64'(f32), 64'd7);
      chk("zero_ill", 64'(il32), 64'd1);
      chk("zero_imm", 64'(imm32), 64'd0);
      chk("zero_tgt", 64'(tg32), 64'd0);
      send(32'h0010009B, 64'h0);
      chk("imm32_rv32_fmt", 64'(f32), 64'd7);
      chk("imm32_rv64_fmt", 64'(f64), 64'd1);
      chk("imm32_rv64_imm", imm64, 64'd1);
      cycle();

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00500093;
      in_pc     = 64'h1000;
      cycle();
      in_instr  = 32'h00A00113;
      in_pc     = 64'h1004;
      cycle();
      chk("bp_ready_low", 64'(r32), 64'd0);
      in_instr  = 32'h00F00193;
      in_pc     = 64'h1008;
      cycle();
      chk("bp_held_ready", 64'(r32), 64'd0);
      chk("bp_held_a", 64'(i32), 64'h00500093);
      out_ready = 1'b1;
      cycle();
      chk("bp_out_b", 64'(i32), 64'h00A00113);
      chk("bp_valid_b", 64'(v32), 64'd1);
      cycle();
      chk("bp_out_c", 64'(i32), 64'h00F00193);
      chk("bp_valid_c", 64'(v32), 64'd1);
      in_valid = 1'b0;
      cycle();
      chk("bp_empty", 64'(v32), 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00500093;
      cycle();
      in_instr  = 32'h00A00113;
      cycle();
      in_instr  = 32'h0FF00213;
      flush     = 1'b1;
      cycle();
      flush     = 1'b0;
      in_valid  = 1'b0;
      chk("fl_valid", 64'(v32), 64'd0);
      chk("fl_ready", 64'(r32), 64'd1);
      chk("fl_valid64", 64'(v64), 64'd0);
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("fl_no_ghost", 64'(v32), 64'd0);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFE000EE3;
      in_pc     = 64'h500;
      cycle();
      in_instr  = 32'h0080006F;
      cycle();
      in_valid  = 1'b0;
      #2 rst    = 1'b1;
      #1;
      chk("arst_valid", 64'(v32), 64'd0);
      chk("arst_ready", 64'(r32), 64'd1);
      chk("arst_instr", 64'(i32), 64'd0);
      chk("arst_imm", 64'(imm32), 64'd0);
      chk("arst_fmt", 64'(f32), 64'd0);
      chk("arst_tgt", 64'(tg32), 64'd0);
      chk("arst_valid64", 64'(v64), 64'd0);
      q.delete();
      cycle();
      rst       = 1'b0;
      out_ready = 1'b1;
      send(32'h0080006F, 64'h300);
      chk("post_rst_valid", 64'(v32), 64'd1);
      chk("post_rst_instr", 64'(i32), 64'h0080006F);
      chk("post_rst_tgt", 64'(tg32), 64'h308);

      repeat (400) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         flush     = ($urandom_range(40) == 0);
         in_instr  = $urandom;
         if ($urandom_range(4) != 0)
            in_instr[6:0] = ops[$urandom_range(12)];
         in_pc = {$urandom, $urandom};
         cycle();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
